hal1_seq_ctrl: RTL
==================

Name: hal1_seq_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer for the HAL1 accumulator machine.
- Owns the program counter and instruction register, and issues every instruction and operand access to the shared 32-bit instruction/data memory through a req/ack handshake.
- Drives load strobes to the external 32-bit accumulator datapath.
- Replaces the single-cycle always-block sequencing with a controller that tolerates variable memory latency.

Parameters:
PC_RESET, 13'h0000, pc value loaded on reset
TIMEOUT, 16, max cycles mem_req may stay unacknowledged before error halt (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
run  in  1  start pulse; sampled only in IDLE
mem_req  out  1  memory access request, held until ack
mem_we  out  1  1=write (accumulator to mem_addr), valid with mem_req
mem_addr  out  13  memory word address, valid with mem_req
mem_ack  in  1  access complete this cycle; ignored when mem_req=0
mem_rdata  in  32  read data, valid when mem_ack=1 and mem_we=0
acc_ld  out  1  one-cycle accumulator update strobe
acc_op  out  2  00 LOAD (acc<=operand), 01 SUB (acc<=acc-operand), 10 NEG (acc<=-operand)
acc_operand  out  32  latched operand for the accumulator
pc  out  13  current program counter
ir  out  16  current instruction
halted  out  1  1 in HALT state
err  out  1  sticky memory-timeout flag

Behaviour:
- Reset: state=IDLE, pc=PC_RESET, ir=0, acc_operand=0, and mem_req, mem_we, acc_ld, halted, err all 0. Reset takes priority in every state, including mid-handshake; mem_req is low in the cycle after reset is sampled.
- Instruction format: ir[15:13] is the opcode, ir[12:0] is the operand address a.
- Opcodes:
  - 000 JMP: pc<=M[a][12:0]
  - 001 JRP: pc<=pc+M[a][12:0], mod 2^13
  - 010 LDA: acc<=M[a]
  - 011 STO: M[a]<=acc
  - 100 and 101 SUB: acc<=acc-M[a]
  - 110 LDN: acc<=-M[a]
  - 111 STP: halt
- All outputs are registered.
- States and transitions:
  - IDLE: run=1 -> FETCH.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack, ir<=mem_rdata[15:0] -> DECODE.
  - DECODE (1 cycle): opcode 111 -> HALT; else -> OPERAND.
  - OPERAND: mem_req=1, mem_addr=ir[12:0], mem_we=1 only for STO. On ack, acc_operand<=mem_rdata (unchanged for STO) -> EXEC.
  - EXEC (1 cycle): acc_ld=1 with acc_op for LDA, SUB and LDN; acc_ld=0 for JMP, JRP and STO. pc updates per opcode; non-jumps use pc+1. Then -> FETCH.
  - HALT: halted=1. Stays until reset; run is ignored.
- Handshake:
  - mem_req rises on the state-entry cycle. mem_addr and mem_we are stable while mem_req=1.
  - An ack in the same cycle completes the access, and mem_req is 0 the next cycle.
  - Zero-wait memory (ack tied 1) gives 4 cycles per non-STP instruction: FETCH, DECODE, OPERAND, EXEC.
- Timeout: a counter clears on entry to FETCH/OPERAND and increments each unacked cycle. When it reaches TIMEOUT with no ack, err<=1, mem_req<=0, and the state goes to HALT.
- Wrap-around:
  - pc+1 from 13'h1FFF gives 0.
  - JRP adds as an unsigned 13-bit value and wraps.
  - Upper bits of M[a] above bit 12 are ignored for jumps.
- run asserted outside IDLE has no effect.
- An ack arriving while mem_req=0 has no effect.
- pc and ir hold their values in HALT.

Test Plan:
1. Zero-wait memory, M[0]=16'h4005 (LDA 5), M[5]=32'h0000_002A, run pulse -> FETCH addr 0, OPERAND addr 5; EXEC cycle acc_ld=1, acc_op=00, acc_operand=42; pc=1; 4 cycles total.
2. M[1]=16'h8006 (SUB 6), M[6]=7 -> acc_op=01, operand 7; M[2]=16'h6007 (STO 7) -> mem_req with mem_we=1, addr 7, acc_ld=0; pc=3.
3. pc=13'h1FFF holding 16'h2003 (JRP 3), M[3]=2 -> pc=13'h0001 (wrap). M[0]=16'h0004 (JMP 4), M[4]=32'hFFFF_0010 -> pc=13'h0010.
4. ack delayed 3 cycles on fetch -> mem_req high 3 cycles with addr stable; ir latched on the ack cycle; mem_req low next cycle.
5. ack never asserted, TIMEOUT=16 -> after 16 unacked cycles err=1, halted=1, mem_req=0; run pulse has no effect; reset clears err and returns to IDLE with pc=PC_RESET.
6. Instruction 16'hE000 (STP) -> halted=1 after DECODE, no OPERAND access, pc unchanged. Reset asserted mid-OPERAND wait -> next cycle mem_req=0, state IDLE.

Source files
------------

// File: rtl/hal1_seq_ctrl.sv
// hal1_seq_ctrl
//   Multi-cycle fetch/decode/execute sequencer for the HAL1 accumulator
//   machine. It owns the program counter and the instruction register. It
//   issues every instruction fetch and operand access to the shared 32-bit
//   memory through a req/ack handshake, so memory latency can vary. It also
//   drives one-cycle load strobes to the external accumulator datapath.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   run          start pulse, only looked at while idle
//   mem_req      memory request, held until mem_ack
//   mem_we       1 = write accumulator to mem_addr (STO), valid with mem_req
//   mem_addr     13-bit memory word address, valid with mem_req
//   mem_ack      access completes this cycle (ignored while mem_req = 0)
//   mem_rdata    32-bit read data, valid with mem_ack on reads
//   acc_ld       one-cycle accumulator update strobe
//   acc_op       00 LOAD, 01 SUB, 10 NEG
//   acc_operand  operand latched from the last operand read
//   pc           program counter
//   ir           instruction register
//   halted       1 while in HALT
//   err          sticky memory-timeout flag
module hal1_seq_ctrl #(
  parameter logic [12:0] PC_RESET = 13'h0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        acc_ld,
  output logic [1:0]  acc_op,
  output logic [31:0] acc_operand,
  output logic [12:0] pc,
  output logic [15:0] ir,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_e;

  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_JRP = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STO = 3'b011;
  localparam logic [2:0] OP_SB0 = 3'b100;
  localparam logic [2:0] OP_SB1 = 3'b101;
  localparam logic [2:0] OP_LDN = 3'b110;
  localparam logic [2:0] OP_STP = 3'b111;

  localparam logic [1:0] ACC_LOAD = 2'b00;
  localparam logic [1:0] ACC_SUB  = 2'b01;
  localparam logic [1:0] ACC_NEG  = 2'b10;

  // The counter holds the number of unacknowledged cycles already spent in
  // the current access. It only has to reach TIMEOUT-1.
  localparam int unsigned CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [12:0]   pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [31:0]   opnd_q, opnd_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [12:0]   addr_q, addr_d;
  logic          accld_q, accld_d;
  logic [1:0]    accop_q, accop_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic [2:0]    opcode;
  logic          tmoHit;

  assign opcode = ir_q[15:13];
  assign tmoHit = (tmo_q == TMO_LAST);

  // State and output registers. Reset wins over everything, including an
  // access that is still waiting for its ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      opnd_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      accld_q  <= 1'b0;
      accop_q  <= ACC_LOAD;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opnd_q   <= opnd_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      accld_q  <= accld_d;
      accop_q  <= accop_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state logic. Every output is computed one cycle ahead so that
  // mem_req is already high in the first cycle of FETCH/OPERAND. It drops in
  // the cycle after the ack, or after a timeout. An ack arriving together
  // with the last allowed cycle still completes the access.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opnd_d   = opnd_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    accld_d  = 1'b0;
    accop_d  = accop_q;
    halted_d = halted_q;
    err_d    = err_q;
    tmo_d    = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pc_q;
          tmo_d   = '0;
        end
      end

      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata[15:0];
          req_d   = 1'b0;
          state_d = S_DECODE;
        end else if (tmoHit) begin
          err_d    = 1'b1;
          req_d    = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DECODE: begin
        if (opcode == OP_STP) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_OPERAND;
          req_d   = 1'b1;
          we_d    = (opcode == OP_STO);
          addr_d  = ir_q[12:0];
          tmo_d   = '0;
        end
      end

      S_OPERAND: begin
        if (mem_ack) begin
          if (opcode != OP_STO) begin
            opnd_d = mem_rdata;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_EXEC;
          case (opcode)
            OP_LDA: begin
              accld_d = 1'b1;
              accop_d = ACC_LOAD;
            end
            OP_SB0, OP_SB1: begin
              accld_d = 1'b1;
              accop_d = ACC_SUB;
            end
            OP_LDN: begin
              accld_d = 1'b1;
              accop_d = ACC_NEG;
            end
            default: accld_d = 1'b0;
          endcase
        end else if (tmoHit) begin
          err_d    = 1'b1;
          req_d    = 1'b0;
          we_d     = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      // Jump targets come from the latched operand. Only its low 13 bits
      // matter, and pc arithmetic wraps naturally at 13 bits.
      S_EXEC: begin
        case (opcode)
          OP_JMP:  pc_d = opnd_q[12:0];
          OP_JRP:  pc_d = pc_q + opnd_q[12:0];
          default: pc_d = pc_q + 13'd1;
        endcase
        state_d = S_FETCH;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = pc_d;
        tmo_d   = '0;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign acc_ld      = accld_q;
  assign acc_op      = accop_q;
  assign acc_operand = opnd_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule
